// File: rtl/alu_frame_sequencer.sv
// alu_frame_sequencer
// Walks the stored frame in raster order and issues one ALU read per output
// pixel when the memory controller grants it. The matching write strobe comes
// out a fixed PIPE_LAT cycles later, when the ALU result emerges.
//
// Build option: define ALU_SEQ_BORDER_EN to scan the full frame, rows
// 0..V_RES-1 and columns 0..H_RES-1, so the address simply increments. The
// ALU then handles the out-of-frame taps. Without it, only interior pixels
// are scanned, so the 3x3 window never leaves the frame.
//
// Handshake: a read transfers on every cycle where ren_alu is high.
// ren_alu = (state == RUN) & gnt, so gnt plays the role of ready and the
// address holds while gnt is low. The write side has no back-pressure.
// Each transferred read produces exactly one wen_alu pulse PIPE_LAT cycles
// later. Gaps in gnt show up as matching gaps in wen_alu.
module alu_frame_sequencer #(
  parameter int H_RES    = 320,
  parameter int V_RES    = 240,
  parameter int AW       = 17,
  parameter int PIPE_LAT = 4
) (
  input  logic          CLK100MHZ,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          pass_thru,
  input  logic          gnt,
  output logic          ren_alu,
  output logic [AW-1:0] raddr_alu,
  output logic          wen_alu,
  output logic [AW-1:0] waddr_alu,
  output logic          busy,
  output logic          done
);

  // Scan window bounds and the address step applied at a row wrap.
  // When the column wraps from LAST_COL back to FIRST_COL, the address moves
  // by (H_RES - LAST_COL) + FIRST_COL. That step is 3 for the interior scan
  // and 1 for the full-frame scan.
`ifdef ALU_SEQ_BORDER_EN
  localparam int FIRST_ROW = 0;
  localparam int LAST_ROW  = V_RES - 1;
  localparam int FIRST_COL = 0;
  localparam int LAST_COL  = H_RES - 1;
  localparam int WRAP_STEP = 1;
`else
  localparam int FIRST_ROW = 1;
  localparam int LAST_ROW  = V_RES - 2;
  localparam int FIRST_COL = 1;
  localparam int LAST_COL  = H_RES - 2;
  localparam int WRAP_STEP = 3;
`endif

  // Elaboration-time constant; no multiplier is built.
  localparam int FIRST_ADDR = FIRST_ROW * H_RES + FIRST_COL;
  localparam int RW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int CW = (H_RES > 1) ? $clog2(H_RES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [RW-1:0]       row_q;
  logic [CW-1:0]       col_q;
  logic [AW-1:0]       addr_q;
  logic                col_last;
  logic                px_last;

  logic [PIPE_LAT-1:0] vld_q;
  logic [PIPE_LAT-1:0] vld_shift;
  logic [AW-1:0]       addr_pipe_q [PIPE_LAT];

  // Read request, scan-position decode and the valid pipe's next value.
  always_comb begin
    ren_alu  = (state_q == RUN) && gnt;
    col_last = (col_q == CW'(LAST_COL));
    px_last  = col_last && (row_q == RW'(LAST_ROW));
    // The valid pipe shifts in ren_alu at its low end, and the top stage
    // drops out. DRAIN tests this next value, so DONE lands in the cycle
    // right after the final wen_alu.
    vld_shift = PIPE_LAT'({vld_q, ren_alu});
  end

  // State register.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Abort overrides everything, including a start in the
  // same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!abort && start && !pass_thru) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (ren_alu && px_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (vld_shift == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs. An abort in DONE suppresses the done pulse.
  always_comb begin
    busy = (state_q == RUN) || (state_q == DRAIN);
    done = (state_q == DONE) && !abort;
  end

  // Raster counters and the incremental centre-pixel address.
  // Outside RUN, and whenever a pass is abandoned or completed, the counters
  // sit on the first scan pixel. Each new pass therefore starts there.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= RW'(FIRST_ROW);
      col_q  <= CW'(FIRST_COL);
      addr_q <= AW'(FIRST_ADDR);
    end else if ((state_q != RUN) || abort || (ren_alu && px_last)) begin
      row_q  <= RW'(FIRST_ROW);
      col_q  <= CW'(FIRST_COL);
      addr_q <= AW'(FIRST_ADDR);
    end else if (ren_alu) begin
      if (col_last) begin
        row_q  <= row_q + RW'(1);
        col_q  <= CW'(FIRST_COL);
        addr_q <= addr_q + AW'(WRAP_STEP);
      end else begin
        col_q  <= col_q + CW'(1);
        addr_q <= addr_q + AW'(1);
      end
    end
  end

  assign raddr_alu = addr_q;

  // Valid pipe. It shifts every cycle; abort empties it so that reads still
  // in flight never produce a write.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (abort) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_shift;
    end
  end

  // Address pipe. It tracks the valid pipe stage for stage; its contents
  // only matter where the matching valid bit is set.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        addr_pipe_q[i] <= '0;
      end
    end else begin
      addr_pipe_q[0] <= addr_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        addr_pipe_q[i] <= addr_pipe_q[i-1];
      end
    end
  end

  assign wen_alu   = vld_q[PIPE_LAT-1];
  assign waddr_alu = addr_pipe_q[PIPE_LAT-1];

endmodule

// File: tb/tb_alu_frame_sequencer.sv
// Testbench for alu_frame_sequencer on an 8x6 frame with an ALU latency of 4.
// Follows the build option ALU_SEQ_BORDER_EN for the expected scan.
module tb_alu_frame_sequencer;

  localparam int H  = 8;
  localparam int V  = 6;
  localparam int AW = 17;
  localparam int L  = 4;
`ifdef ALU_SEQ_BORDER_EN
  localparam int P_EXP      = 48;
  localparam int FIRST_EXP  = 0;
`else
  localparam int P_EXP      = 24;
  localparam int FIRST_EXP  = 9;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst_n;
  logic          start;
  logic          abort;
  logic          pass_thru;
  logic          gnt;
  logic          ren_alu;
  logic [AW-1:0] raddr_alu;
  logic          wen_alu;
  logic [AW-1:0] waddr_alu;
  logic          busy;
  logic          done;

  alu_frame_sequencer #(
    .H_RES(H),
    .V_RES(V),
    .AW(AW),
    .PIPE_LAT(L)
  ) dut (
    .CLK100MHZ(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .pass_thru(pass_thru),
    .gnt(gnt),
    .ren_alu(ren_alu),
    .raddr_alu(raddr_alu),
    .wen_alu(wen_alu),
    .waddr_alu(waddr_alu),
    .busy(busy),
    .done(done)
  );

  // ---------------- scoreboard state ----------------
  logic [AW-1:0] rd_exp[$];   // expected read addresses, in order
  logic [AW-1:0] exp_q[$];    // expected write addresses
  int            exp_t[$];    // expected write cycles
  int n_checks = 0;
  int n_errors = 0;
  int reads = 0;
  int writes = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_wr_cyc = -100;

  typedef struct {
    string name;
    int    gnt_mode;      // 0: gnt held high, 1: gnt 1,0,1,0 from first RUN cycle
    logic  restart_mid;   // re-pulse start in RUN
    logic  pt_mid;        // raise pass_thru mid-pass
    int    exp_reads;
    int    exp_done_lat;  // cycles from start cycle to done cycle
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got 1 expected 0 (cycle %0d)", name, cyc);
  endtask

  // Sample DUT outputs mid-cycle and score them.
  task automatic sample();
    logic [AW-1:0] a;
    int t;
    if (wen_alu) begin
      writes++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        fail_event("unexpected_write");
      end else begin
        a = exp_q.pop_front();
        t = exp_t.pop_front();
        chk("waddr", 32'(waddr_alu), 32'(a));
        chk("write_cycle", cyc, t);
      end
    end
    if (ren_alu) begin
      reads++;
      if (rd_exp.size() == 0) begin
        fail_event("unexpected_read");
      end else begin
        a = rd_exp.pop_front();
        chk("raddr", 32'(raddr_alu), 32'(a));
      end
      if (!abort) begin
        exp_q.push_back(raddr_alu);
        exp_t.push_back(cyc + L);
      end
    end else if (busy && !gnt && rd_exp.size() > 0) begin
      chk("raddr_hold", 32'(raddr_alu), 32'(rd_exp[0]));
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("done_after_last_write", cyc - last_wr_cyc, 1);
      chk("busy_low_at_done", 32'(busy), 0);
    end
    if (abort) begin
      exp_q.delete();
      exp_t.delete();
    end
  endtask

  // Sample the current cycle, then return 1 time unit after the next edge.
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic load_expected_reads();
    rd_exp.delete();
`ifdef ALU_SEQ_BORDER_EN
    for (int a = 0; a < H * V; a++) rd_exp.push_back(AW'(a));
`else
    for (int r = 1; r <= V - 2; r++)
      for (int c = 1; c <= H - 2; c++)
        rd_exp.push_back(AW'(r * H + c));
`endif
  endtask

  task automatic run_pass(input vec_t v);
    int base_r, base_w, base_d, s_cyc, k;
    base_r = reads;
    base_w = writes;
    base_d = done_cnt;
    load_expected_reads();
    start = 1'b1;
    pass_thru = 1'b0;
    gnt = 1'b1;
    s_cyc = cyc;
    tick();
    start = 1'b0;
    chk({v.name, "_busy_after_start"}, 32'(busy), 1);
    for (int t = 0; t < 400 && done_cnt == base_d; t++) begin
      k = cyc - s_cyc;
      gnt = (v.gnt_mode == 0) ? 1'b1 : ((k % 2) == 1);
      start = v.restart_mid && (k == 5);
      pass_thru = v.pt_mid && (k >= 3);
      tick();
    end
    start = 1'b0;
    pass_thru = 1'b0;
    gnt = 1'b1;
    repeat (4) tick();
    chk({v.name, "_reads"}, reads - base_r, v.exp_reads);
    chk({v.name, "_writes"}, writes - base_w, v.exp_reads);
    chk({v.name, "_done_count"}, done_cnt - base_d, 1);
    chk({v.name, "_done_latency"}, done_cyc - s_cyc, v.exp_done_lat);
    chk({v.name, "_busy_idle"}, 32'(busy), 0);
    chk({v.name, "_reads_left"}, rd_exp.size(), 0);
    chk({v.name, "_writes_left"}, exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base_r, w_snap, d_snap;

    vecs[0] = '{"gnt_high",       0, 1'b0, 1'b0, P_EXP, P_EXP + L + 1};
    vecs[1] = '{"gnt_toggle",     1, 1'b0, 1'b0, P_EXP, 2 * P_EXP + L};
    vecs[2] = '{"restart_mid",    0, 1'b1, 1'b0, P_EXP, P_EXP + L + 1};
    vecs[3] = '{"pass_thru_mid",  0, 1'b0, 1'b1, P_EXP, P_EXP + L + 1};
    vecs[4] = '{"toggle_restart", 1, 1'b1, 1'b1, P_EXP, 2 * P_EXP + L};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    pass_thru = 1'b0;
    gnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ren", 32'(ren_alu), 0);
    chk("rst_wen", 32'(wen_alu), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_raddr", 32'(raddr_alu), FIRST_EXP);
    chk("rst_waddr", 32'(waddr_alu), 0);
    rst_n = 1'b1;
    tick();

    // Table-driven passes.
    for (int i = 0; i < 5; i++) run_pass(vecs[i]);

    // start with pass_thru high in IDLE is ignored.
    d_snap = done_cnt;
    pass_thru = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("pass_thru_start_busy", 32'(busy), 0);
      tick();
    end
    pass_thru = 1'b0;

    // abort and start in the same IDLE cycle: abort wins.
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("abort_start_busy", 32'(busy), 0);
      tick();
    end
    chk("ignored_starts_done", done_cnt - d_snap, 0);

    // Abort after 10 accepted reads.
    load_expected_reads();
    base_r = reads;
    d_snap = done_cnt;
    gnt = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 100 && (reads - base_r) < 10; t++) tick();
    chk("abort_reads_before", reads - base_r, 10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    rd_exp.delete();
    chk("abort_idle_next", 32'(busy), 0);
    w_snap = writes;
    repeat (10) tick();
    chk("abort_no_writes", writes - w_snap, 0);
    chk("abort_no_done", done_cnt - d_snap, 0);

    // Next pass restarts at the first scan address.
    run_pass(vecs[0]);

    // Asynchronous reset mid-RUN.
    load_expected_reads();
    gnt = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ren", 32'(ren_alu), 0);
    chk("arst_wen", 32'(wen_alu), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_raddr", 32'(raddr_alu), FIRST_EXP);
    chk("arst_waddr", 32'(waddr_alu), 0);
    rd_exp.delete();
    exp_q.delete();
    exp_t.delete();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_busy", 32'(busy), 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_frame_sequencer.md
# alu_frame_sequencer

Sequences the convolution ALU over one stored frame. On a start pulse it walks the frame buffer in raster order and issues one read request per output pixel, subject to a grant from the memory controller. It then issues the matching write request a fixed number of cycles later, when the ALU result emerges. It sits between `mem_controller` and `ALU` and owns the `raddr_alu`/`ren_alu`/`waddr_alu`/`wen_alu` strobes that those two blocks exchange.

## Interface
Parameters:
- `H_RES`, 320: frame width in pixels.
- `V_RES`, 240: frame height in pixels.
- `AW`, 17: frame-buffer address width; must satisfy 2^AW ≥ H_RES·V_RES.
- `PIPE_LAT`, 4: ALU latency in cycles, from an accepted read to valid result (≥1).

Ports (one clock; reset is asynchronous and active-low):
- `CLK100MHZ`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  pulse: a new frame is complete in the buffer; begin processing.
- `abort`  in  1  synchronous abandon of the current pass.
- `pass_thru`  in  1  processing bypassed; `start` is ignored while high.
- `gnt`  in  1  memory controller accepts a read this cycle.
- `ren_alu`  out  1  read request.
- `raddr_alu`  out  AW  centre-pixel address of the 3×3 window.
- `wen_alu`  out  1  write strobe for the ALU result.
- `waddr_alu`  out  AW  result address.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse when the last write has retired.

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: issuing reads.
  - DRAIN: no more reads; waiting for the pipeline to empty.
  - DONE: one cycle; `done`=1.
- Transitions:
  - IDLE → RUN when `start` & ~`pass_thru`. Row/column counters load to the first pixel.
  - RUN → DRAIN on the edge that accepts the last read.
  - DRAIN → DONE when the valid pipe holds no set bits.
  - DONE → IDLE unconditionally.
- Scan region (default build): interior pixels only.
  - Rows 1..V_RES-2, columns 1..H_RES-2, so the 3×3 window never leaves the frame.
  - Pixel count is (H_RES-2)·(V_RES-2).
  - `raddr_alu` = row·H_RES + col, maintained incrementally with no multiplier.
  - At column H_RES-2: column wraps to 1, row increments, and the address adds 3.
- Read handshake:
  - `ren_alu` = (state==RUN) & `gnt`, combinational.
  - The address and counters advance only on edges where `ren_alu`=1.
  - With `gnt` low, the address holds.
- Write pipeline:
  - Shift registers of depth PIPE_LAT carry a valid bit and an AW-bit address. They shift every cycle; the input is `ren_alu`/`raddr_alu`.
  - `wen_alu` and `waddr_alu` are the last stage, so each accepted read produces exactly one write.
  - The pipe never stalls; `gnt` gaps appear as `wen_alu` gaps.
- `start` in RUN, DRAIN or DONE is ignored, with no queuing.
- `abort` in any state:
  - next state IDLE;
  - valid pipe cleared, so no further `wen_alu`;
  - no `done` pulse.
- `abort` and `start` in the same IDLE cycle: `abort` wins and the block stays in IDLE.
- `pass_thru` rising mid-pass: the pass completes normally.

## Timing
- Reset values:
  - state IDLE;
  - `ren_alu`=0, `wen_alu`=0, `busy`=0, `done`=0;
  - `raddr_alu`=first scan address;
  - `waddr_alu`=0;
  - valid pipe all 0.
- `start` sampled at edge N → `busy`=1 and `ren_alu` may assert from cycle N+1.
- Read accepted at edge K → `wen_alu`=1 with the matching `waddr_alu` during cycle K+PIPE_LAT.
- With `gnt` held high: the first read is in cycle N+1, and the last write is in cycle N+P+PIPE_LAT, where P is the pixel count.
  - DRAIN is entered after the last read is accepted.
  - `done` is high in the cycle after the last `wen_alu`.
  - `busy` falls in the same cycle that `done` rises.
- Earliest next `start` accepted: the cycle after `done`.

## Configuration
- `ALU_SEQ_BORDER_EN` defined:
  - Scan covers the full frame, rows 0..V_RES-1 and columns 0..H_RES-1.
  - Pixel count is H_RES·V_RES and the address simply increments, 0..H_RES·V_RES-1.
  - The ALU handles out-of-frame taps.
- Undefined: interior-only scan as above; no other behaviour changes.

## Test plan
- Default build, H_RES=8, V_RES=6, PIPE_LAT=4, `gnt`=1, pulse `start` → 24 reads:
  - addresses 9..14, 17..22, 25..30, 33..38;
  - 24 writes with identical addresses, each 4 cycles after its read;
  - `done` the cycle after the last write.
- Same setup with `gnt` toggling 1,0,1,0 → address holds on every `gnt`=0 cycle; 24 reads, 24 writes, write order equals read order.
- Build with `ALU_SEQ_BORDER_EN`, H_RES=8, V_RES=6 → 48 reads with addresses 0..47 in order; `done` after the 48th write.
- `abort` after 10 accepted reads → IDLE next cycle; no `wen_alu` afterwards; `done` stays 0; the next `start` restarts at address 9.
- `start` re-pulsed during RUN, and `start` with `pass_thru`=1 in IDLE → both ignored; exactly one `done` per accepted pass.
- Assert `rst_n`=0 mid-RUN, asynchronously → all outputs take their reset values immediately; after release, `busy`=0 until a new `start`.
